// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
// master drives operands and out_ready; slave (the adder) drives results and in_ready.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, carryin, sub, in_valid, out_ready,
        input  in_ready, sum, carryout, overflow, out_valid
    );

    modport slave (
        input  a, b, carryin, sub, in_valid, out_ready,
        output in_ready, sum, carryout, overflow, out_valid
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep add/subtract with a sliced carry chain and valid/ready flow control.
// Define SATURATE_EN to clamp the sum on signed overflow; default build wraps modulo 2^WIDTH.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              resetn,
    pipelined_adder_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [L:0]       v_q;
    logic [L:0]       c_q;
    logic             ov_q;

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic [L:0]       src_v;
    logic [L:0]       src_c;
    logic [L:0]       nxt_c;
    logic [SW:0]      part;
    logic             msb_cin;
    logic             ovf;
    logic [WIDTH-1:0] fin_sum;
    logic             stall;

    assign stall         = v_q[L] && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = v_q[L];
    assign bus.sum       = s_q[L];
    assign bus.carryout  = c_q[L];
    assign bus.overflow  = ov_q;

    // b is inverted on entry so every later slice is a plain add; subtract forces carry-in to 1
    always_comb begin
        src_a[0] = bus.a;
        src_b[0] = bus.b ^ {WIDTH{bus.sub}};
        src_s[0] = '0;
        src_v[0] = bus.in_valid;
        src_c[0] = bus.sub | bus.carryin;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_v[k] = v_q[k-1];
            src_c[k] = c_q[k-1];
        end
        part  = '0;
        nxt_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]} + {{SW{1'b0}}, src_c[k]};
            nxt_s[k]              = src_s[k];
            nxt_s[k][k*SW +: SW]  = part[SW-1:0];
            nxt_c[k]              = part[SW];
        end
    end

    // carry into the MSB is recovered from the MSB's own sum bit
    always_comb begin
        msb_cin = src_a[L][WIDTH-1] ^ src_b[L][WIDTH-1] ^ nxt_s[L][WIDTH-1];
        ovf     = msb_cin ^ nxt_c[L];
`ifdef SATURATE_EN
        fin_sum = ovf ? {~nxt_s[L][WIDTH-1], {(WIDTH-1){nxt_s[L][WIDTH-1]}}} : nxt_s[L];
`else
        fin_sum = nxt_s[L];
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            v_q  <= '0;
            c_q  <= '0;
            ov_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= (k == L) ? fin_sum : nxt_s[k];
            end
            v_q  <= src_v;
            c_q  <= nxt_c;
            ov_q <= ovf;
        end
    end
endmodule
